// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB operand
// forwarding and load-use hazard detection for the 5-stage RV32 core.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      dValid_i,
  input  logic [DATA_WIDTH-1:0]     dPC_i,
  input  logic [DATA_WIDTH-1:0]     dRD1_i,
  input  logic [DATA_WIDTH-1:0]     dRD2_i,
  input  logic [DATA_WIDTH-1:0]     dImm_i,
  input  logic [REG_ADDR_WIDTH-1:0] dRs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] dRs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] dRd_i,
  input  logic [3:0]                dALUCtrl_i,
  input  logic [2:0]                dBranch_i,
  input  logic                      dIsBranch_i,
  input  logic                      dALUSrcA_i,
  input  logic                      dALUSrcB_i,
  input  logic                      dRegWrite_i,
  input  logic                      dMemRead_i,
  input  logic                      dMemWrite_i,
  input  logic [1:0]                dResultSrc_i,
  input  logic [REG_ADDR_WIDTH-1:0] exmemRd_i,
  input  logic                      exmemRegWrite_i,
  input  logic [DATA_WIDTH-1:0]     exmemResult_i,
  input  logic [REG_ADDR_WIDTH-1:0] memwbRd_i,
  input  logic                      memwbRegWrite_i,
  input  logic [DATA_WIDTH-1:0]     memwbResult_i,
  output logic [DATA_WIDTH-1:0]     srcA_o,
  output logic [DATA_WIDTH-1:0]     srcB_o,
  output logic [3:0]                ALUCtrl_o,
  output logic [2:0]                branch_o,
  output logic                      isBranch_o,
  output logic [DATA_WIDTH-1:0]     storeData_o,
  output logic [DATA_WIDTH-1:0]     pc_o,
  output logic [DATA_WIDTH-1:0]     imm_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_o,
  output logic                      valid_o,
  output logic                      regWrite_o,
  output logic                      memRead_o,
  output logic                      memWrite_o,
  output logic [1:0]                resultSrc_o,
  output logic                      loadUseStall_o
);

  // ALU branch condition that never resolves taken; used for bubbles.
  localparam logic [2:0] BR_NEVER = 3'b010;

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [3:0]                alu;
    logic [2:0]                br;
    logic                      isbr;
    logic                      srca;
    logic                      srcb;
    logic                      rw;
    logic                      mr;
    logic                      mw;
    logic [1:0]                rsrc;
  } idex_t;

  idex_t ex_q, ex_d;

  logic [DATA_WIDTH-1:0] fwdA, fwdB;

  // Forwarding select: x0 never forwards, EX/MEM beats MEM/WB.
  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] r,
    input logic [DATA_WIDTH-1:0]     regval,
    input logic                      exw,
    input logic [REG_ADDR_WIDTH-1:0] exrd,
    input logic [DATA_WIDTH-1:0]     exres,
    input logic                      wbw,
    input logic [REG_ADDR_WIDTH-1:0] wbrd,
    input logic [DATA_WIDTH-1:0]     wbres
  );
    if (r == '0)                  return regval;
    else if (exw && (exrd == r))  return exres;
    else if (wbw && (wbrd == r))  return wbres;
    else                          return regval;
  endfunction

  // Next-state: flush loads a bubble, stall holds, otherwise capture decode.
  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (!stall_i) begin
      ex_d.valid = dValid_i;
      ex_d.pc    = dPC_i;
      ex_d.rd1   = dRD1_i;
      ex_d.rd2   = dRD2_i;
      ex_d.imm   = dImm_i;
      ex_d.rs1   = dRs1_i;
      ex_d.rs2   = dRs2_i;
      ex_d.rd    = dRd_i;
      ex_d.alu   = dALUCtrl_i;
      ex_d.br    = dBranch_i;
      ex_d.isbr  = dIsBranch_i & dValid_i;
      ex_d.srca  = dALUSrcA_i;
      ex_d.srcb  = dALUSrcB_i;
      ex_d.rw    = dRegWrite_i & dValid_i;
      ex_d.mr    = dMemRead_i & dValid_i;
      ex_d.mw    = dMemWrite_i & dValid_i;
      ex_d.rsrc  = dResultSrc_i;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign fwdA = fwd_sel(ex_q.rs1, ex_q.rd1, exmemRegWrite_i, exmemRd_i, exmemResult_i,
                        memwbRegWrite_i, memwbRd_i, memwbResult_i);
  assign fwdB = fwd_sel(ex_q.rs2, ex_q.rd2, exmemRegWrite_i, exmemRd_i, exmemResult_i,
                        memwbRegWrite_i, memwbRd_i, memwbResult_i);

  assign srcA_o      = ex_q.srca ? ex_q.pc  : fwdA;
  assign srcB_o      = ex_q.srcb ? ex_q.imm : fwdB;
  assign storeData_o = fwdB;
  assign ALUCtrl_o   = ex_q.alu;
  // A bubble (invalid slot, including after reset/flush) must never branch.
  assign branch_o    = ex_q.valid ? ex_q.br : BR_NEVER;
  assign isBranch_o  = ex_q.isbr;
  assign pc_o        = ex_q.pc;
  assign imm_o       = ex_q.imm;
  assign rd_o        = ex_q.rd;
  assign valid_o     = ex_q.valid;
  assign regWrite_o  = ex_q.rw;
  assign memRead_o   = ex_q.mr;
  assign memWrite_o  = ex_q.mw;
  assign resultSrc_o = ex_q.rsrc;

  assign loadUseStall_o = ex_q.valid & ex_q.mr & (ex_q.rd != '0) & dValid_i &
                          ((ex_q.rd == dRs1_i) | (ex_q.rd == dRs2_i));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with an expectation-queue scoreboard.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, dValid_i;
  logic [31:0] dPC_i, dRD1_i, dRD2_i, dImm_i;
  logic [4:0]  dRs1_i, dRs2_i, dRd_i;
  logic [3:0]  dALUCtrl_i;
  logic [2:0]  dBranch_i;
  logic        dIsBranch_i, dALUSrcA_i, dALUSrcB_i;
  logic        dRegWrite_i, dMemRead_i, dMemWrite_i;
  logic [1:0]  dResultSrc_i;
  logic [4:0]  exmemRd_i, memwbRd_i;
  logic        exmemRegWrite_i, memwbRegWrite_i;
  logic [31:0] exmemResult_i, memwbResult_i;
  logic [31:0] srcA_o, srcB_o, storeData_o, pc_o, imm_o;
  logic [3:0]  ALUCtrl_o;
  logic [2:0]  branch_o;
  logic [4:0]  rd_o;
  logic [1:0]  resultSrc_o;
  logic        isBranch_o, valid_o, regWrite_o, memRead_o, memWrite_o, loadUseStall_o;

  int errors = 0;
  int checks = 0;
  string       exp_tag_q[$];
  logic [31:0] exp_val_q[$];

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .dValid_i(dValid_i), .dPC_i(dPC_i), .dRD1_i(dRD1_i), .dRD2_i(dRD2_i),
    .dImm_i(dImm_i), .dRs1_i(dRs1_i), .dRs2_i(dRs2_i), .dRd_i(dRd_i),
    .dALUCtrl_i(dALUCtrl_i), .dBranch_i(dBranch_i), .dIsBranch_i(dIsBranch_i),
    .dALUSrcA_i(dALUSrcA_i), .dALUSrcB_i(dALUSrcB_i), .dRegWrite_i(dRegWrite_i),
    .dMemRead_i(dMemRead_i), .dMemWrite_i(dMemWrite_i), .dResultSrc_i(dResultSrc_i),
    .exmemRd_i(exmemRd_i), .exmemRegWrite_i(exmemRegWrite_i), .exmemResult_i(exmemResult_i),
    .memwbRd_i(memwbRd_i), .memwbRegWrite_i(memwbRegWrite_i), .memwbResult_i(memwbResult_i),
    .srcA_o(srcA_o), .srcB_o(srcB_o), .ALUCtrl_o(ALUCtrl_o), .branch_o(branch_o),
    .isBranch_o(isBranch_o), .storeData_o(storeData_o), .pc_o(pc_o), .imm_o(imm_o),
    .rd_o(rd_o), .valid_o(valid_o), .regWrite_o(regWrite_o), .memRead_o(memRead_o),
    .memWrite_o(memWrite_o), .resultSrc_o(resultSrc_o), .loadUseStall_o(loadUseStall_o)
  );

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(val);
  endtask

  task automatic check(input logic [31:0] obs);
    string       tag;
    logic [31:0] val;
    checks++;
    if (exp_tag_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
    end else begin
      tag = exp_tag_q.pop_front();
      val = exp_val_q.pop_front();
      assert (obs === val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_instr(input logic v, input logic [31:0] pc, input logic [31:0] r1,
                             input logic [31:0] r2, input logic [31:0] imm,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [3:0] alu, input logic sa, input logic sb,
                             input logic rw, input logic mr, input logic mw);
    dValid_i = v; dPC_i = pc; dRD1_i = r1; dRD2_i = r2; dImm_i = imm;
    dRs1_i = rs1; dRs2_i = rs2; dRd_i = rd; dALUCtrl_i = alu;
    dALUSrcA_i = sa; dALUSrcB_i = sb; dRegWrite_i = rw; dMemRead_i = mr; dMemWrite_i = mw;
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    dBranch_i = 3'b101; dIsBranch_i = 1'b1; dResultSrc_i = 2'b11;
    exmemRd_i = '0; exmemRegWrite_i = 1'b0; exmemResult_i = '0;
    memwbRd_i = '0; memwbRegWrite_i = 1'b0; memwbResult_i = '0;
    drive_instr(1'b1, 32'h1234, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, 4'h5,
                1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Reset held two cycles with non-zero decode inputs.
    tick(); tick();
    expect_val("rst_valid", 32'h0);   check(32'(valid_o));
    expect_val("rst_srcA", 32'h0);    check(srcA_o);
    expect_val("rst_srcB", 32'h0);    check(srcB_o);
    expect_val("rst_branch", 32'h2);  check(32'(branch_o));
    expect_val("rst_regWrite", 32'h0); check(32'(regWrite_o));
    expect_val("rst_pc", 32'h0);      check(pc_o);
    expect_val("rst_rsrc", 32'h0);    check(32'(resultSrc_o));
    expect_val("rst_isBranch", 32'h0); check(32'(isBranch_o));

    // Plain capture, no forwarding.
    rst_i = 1'b0; dBranch_i = 3'b000; dIsBranch_i = 1'b0; dResultSrc_i = 2'b01;
    drive_instr(1'b1, 32'h100, 32'd5, 32'd7, 32'h44, 5'd1, 5'd2, 5'd9, 4'h0,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_val("cap_srcA", 32'd5); expect_val("cap_srcB", 32'd7);
    expect_val("cap_alu", 32'h0);  expect_val("cap_pc", 32'h100);
    expect_val("cap_rd", 32'd9);   expect_val("cap_valid", 32'h1);
    expect_val("cap_branch", 32'h0); expect_val("cap_store", 32'd7);
    tick();
    check(srcA_o); check(srcB_o); check(32'(ALUCtrl_o)); check(pc_o);
    check(32'(rd_o)); check(32'(valid_o)); check(32'(branch_o)); check(storeData_o);

    // PC / immediate operand selection; storeData still rs2.
    drive_instr(1'b1, 32'h200, 32'd5, 32'd7, 32'h44, 5'd1, 5'd2, 5'd9, 4'h3,
                1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_val("sel_srcA_pc", 32'h200); expect_val("sel_srcB_imm", 32'h44);
    expect_val("sel_store", 32'd7);     expect_val("sel_alu", 32'h3);
    tick();
    check(srcA_o); check(srcB_o); check(storeData_o); check(32'(ALUCtrl_o));

    // Forwarding priority on rs1.
    drive_instr(1'b1, 32'h300, 32'h11, 32'h22, 32'h0, 5'd3, 5'd8, 5'd10, 4'h0,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exmemRd_i = 5'd3; exmemRegWrite_i = 1'b1; exmemResult_i = 32'hAA;
    memwbRd_i = 5'd3; memwbRegWrite_i = 1'b1; memwbResult_i = 32'hBB;
    expect_val("fwd_exmem", 32'hAA);
    tick();
    check(srcA_o);
    expect_val("fwd_memwb", 32'hBB);
    exmemRegWrite_i = 1'b0; #1;
    check(srcA_o);
    expect_val("fwd_none", 32'h11);
    memwbRegWrite_i = 1'b0; #1;
    check(srcA_o);
    expect_val("fwd_rs2_memwb", 32'h5A);
    memwbRd_i = 5'd8; memwbRegWrite_i = 1'b1; memwbResult_i = 32'h5A; #1;
    check(storeData_o);
    memwbRegWrite_i = 1'b0;

    // x0 never forwards.
    drive_instr(1'b1, 32'h400, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd11, 4'h0,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exmemRd_i = 5'd0; exmemRegWrite_i = 1'b1; exmemResult_i = 32'hFF;
    memwbRd_i = 5'd0; memwbRegWrite_i = 1'b1; memwbResult_i = 32'hEE;
    expect_val("x0_srcB", 32'h0); expect_val("x0_store", 32'h0); expect_val("x0_srcA", 32'h0);
    tick();
    check(srcB_o); check(storeData_o); check(srcA_o);
    exmemRegWrite_i = 1'b0; memwbRegWrite_i = 1'b0;

    // Stall three cycles: contents frozen while decode inputs change.
    drive_instr(1'b1, 32'h500, 32'h55, 32'h66, 32'h0, 5'd6, 5'd7, 5'd12, 4'h2,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    stall_i = 1'b1;
    drive_instr(1'b0, 32'h999, 32'h77, 32'h88, 32'h1, 5'd13, 5'd14, 5'd15, 4'h9,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_val("stall_pc", 32'h500); expect_val("stall_srcA", 32'h55);
      expect_val("stall_valid", 32'h1); expect_val("stall_memWrite", 32'h1);
      tick();
      check(pc_o); check(srcA_o); check(32'(valid_o)); check(32'(memWrite_o));
    end

    // Flush and stall together: flush wins.
    flush_i = 1'b1;
    expect_val("flush_valid", 32'h0); expect_val("flush_regWrite", 32'h0);
    expect_val("flush_memWrite", 32'h0); expect_val("flush_branch", 32'h2);
    tick();
    check(32'(valid_o)); check(32'(regWrite_o)); check(32'(memWrite_o)); check(32'(branch_o));
    flush_i = 1'b0; stall_i = 1'b0;

    // Invalid decode slot: controls gated, branch forced never-taken.
    dBranch_i = 3'b001; dIsBranch_i = 1'b1;
    drive_instr(1'b0, 32'h600, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 4'h1,
                1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_val("inv_regWrite", 32'h0); expect_val("inv_memRead", 32'h0);
    expect_val("inv_memWrite", 32'h0); expect_val("inv_isBranch", 32'h0);
    expect_val("inv_branch", 32'h2);   expect_val("inv_pc", 32'h600);
    tick();
    check(32'(regWrite_o)); check(32'(memRead_o)); check(32'(memWrite_o));
    check(32'(isBranch_o)); check(32'(branch_o)); check(pc_o);

    // Valid branch passes its condition through.
    dValid_i = 1'b1;
    expect_val("br_branch", 32'h1); expect_val("br_isBranch", 32'h1);
    tick();
    check(32'(branch_o)); check(32'(isBranch_o));
    dIsBranch_i = 1'b0; dBranch_i = 3'b000;

    // Reset during stall clears state.
    stall_i = 1'b1; rst_i = 1'b1;
    expect_val("rststall_valid", 32'h0); expect_val("rststall_pc", 32'h0);
    tick();
    check(32'(valid_o)); check(pc_o);
    rst_i = 1'b0; stall_i = 1'b0;

    // Load-use detection against a registered load with rd = 4.
    drive_instr(1'b1, 32'h700, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd4, 4'h0,
                1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    dRs1_i = 5'd4; dRs2_i = 5'd9; dValid_i = 1'b1; #1;
    expect_val("lu_rs1", 32'h1); check(32'(loadUseStall_o));
    dRs1_i = 5'd5; dRs2_i = 5'd4; #1;
    expect_val("lu_rs2", 32'h1); check(32'(loadUseStall_o));
    dValid_i = 1'b0; #1;
    expect_val("lu_dinvalid", 32'h0); check(32'(loadUseStall_o));
    dRs1_i = 5'd5; dRs2_i = 5'd6; dValid_i = 1'b1; #1;
    expect_val("lu_nomatch", 32'h0); check(32'(loadUseStall_o));

    // Same load with rd = 0 never stalls.
    drive_instr(1'b1, 32'h704, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 4'h0,
                1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    dRs1_i = 5'd0; dRs2_i = 5'd0; #1;
    expect_val("lu_rd0", 32'h0); check(32'(loadUseStall_o));

    if (exp_tag_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d pending expected 0", exp_tag_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register and operand-forwarding stage for the 5-stage RV32 core. It captures decoded operands and control each cycle, then resolves EX/MEM and MEM/WB forwarding. It drives the ALU's `srcA_i`, `srcB_i`, `ALUCtrl_i` and `branch_i`. It also detects load-use hazards so the hazard controller can stall fetch/decode and bubble this stage.

## Interface
- `DATA_WIDTH`, 32: datapath width.
- `REG_ADDR_WIDTH`, 5: register index width.

- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `stall_i`  in  1  hold current contents.
- `flush_i`  in  1  load a bubble (priority over `stall_i`).
- `dValid_i`  in  1  decode slot holds a real instruction.
- `dPC_i`, `dRD1_i`, `dRD2_i`, `dImm_i`  in  DATA_WIDTH  PC, register-file reads, sign-extended immediate.
- `dRs1_i`, `dRs2_i`, `dRd_i`  in  REG_ADDR_WIDTH  source and destination indices.
- `dALUCtrl_i`  in  4  ALU opcode.
- `dBranch_i`  in  3  funct3 branch condition.
- `dIsBranch_i`  in  1  instruction is a conditional branch.
- `dALUSrcA_i`  in  1  0 = rs1, 1 = PC.
- `dALUSrcB_i`  in  1  0 = rs2, 1 = imm.
- `dRegWrite_i`, `dMemRead_i`, `dMemWrite_i`  in  1  writeback, load, store controls.
- `dResultSrc_i`  in  2  writeback mux select, passed through.
- `exmemRd_i`  in  REG_ADDR_WIDTH  EX/MEM destination index.
- `exmemRegWrite_i`  in  1  EX/MEM writeback enable.
- `exmemResult_i`  in  DATA_WIDTH  EX/MEM ALU result.
- `memwbRd_i`  in  REG_ADDR_WIDTH  MEM/WB destination index.
- `memwbRegWrite_i`  in  1  MEM/WB writeback enable.
- `memwbResult_i`  in  DATA_WIDTH  MEM/WB writeback value.
- `srcA_o`, `srcB_o`  out  DATA_WIDTH  ALU operands.
- `ALUCtrl_o`  out  4  ALU opcode.
- `branch_o`  out  3  ALU branch condition.
- `isBranch_o`  out  1  registered branch flag, gated by valid.
- `storeData_o`  out  DATA_WIDTH  forwarded rs2 value for stores.
- `pc_o`, `imm_o`  out  DATA_WIDTH  registered PC and immediate.
- `rd_o`  out  REG_ADDR_WIDTH  registered destination index.
- `valid_o`, `regWrite_o`, `memRead_o`, `memWrite_o`  out  1  registered controls, gated by valid.
- `resultSrc_o`  out  2  registered writeback select.
- `loadUseStall_o`  out  1  load-use hazard detected.

## Operation
- Register update on each rising edge, in priority order:
  - `rst_i`: all registers cleared to 0.
  - `flush_i`: all registers cleared to 0 (bubble).
  - `stall_i`: all registers hold.
  - Otherwise: every `d*` input is captured.
- Control gating on capture:
  - If `dValid_i` = 0, regWrite, memRead, memWrite and isBranch are captured as 0.
  - `branch_o` is then forced to 3'b010, which the ALU decodes as never-taken.
- Forwarding, combinational, evaluated per operand with `r` = registered rs1 or rs2:
  - `r == 0`: no forwarding; use the registered RD value.
  - Else if `exmemRegWrite_i` and `exmemRd_i == r`: use `exmemResult_i`. EX/MEM has priority.
  - Else if `memwbRegWrite_i` and `memwbRd_i == r`: use `memwbResult_i`.
  - Else: use the registered RD1/RD2.
- Operand selection:
  - `srcA_o` = PC when ALUSrcA = 1, otherwise forwarded rs1.
  - `srcB_o` = imm when ALUSrcB = 1, otherwise forwarded rs2.
  - `storeData_o` is always forwarded rs2, independent of ALUSrcB.
- Load-use detection, combinational:
  - `loadUseStall_o` = `valid_o & memRead_o & (rd_o != 0) & dValid_i & ((rd_o == dRs1_i) | (rd_o == dRs2_i))`.
  - The external hazard controller responds by stalling PC/IF-ID and asserting `flush_i` here for one cycle.

## Timing
- Latency: decode inputs appear on registered outputs 1 cycle after capture.
- Forwarded outputs settle combinationally in the same cycle as the forwarding inputs change.
- Reset values: every output is 0, except `branch_o` = 3'b010.
  - Consequence: `srcA_o` and `srcB_o` equal the forwarding result of rs = 0, which is 0.
- `flush_i` and `stall_i` asserted together: flush wins.
- Reset asserted mid-stall: state clears on the next edge; `stall_i` is ignored.
- `stall_i` held for N cycles: outputs stay constant for N cycles.
  - Forwarded operands may still change if the EX/MEM or MEM/WB inputs change during the stall; this is required behaviour.
- No combinational path exists from any `d*` input to `srcA_o`/`srcB_o`.
- `loadUseStall_o` is combinational from `d*` inputs and registered state only.

## Test plan
- Reset: hold `rst_i` for 2 cycles with `d*` inputs non-zero.
  - Required: all outputs 0, `branch_o` = 3'b010, `valid_o` = 0.
- Capture: `dRD1` = 5, `dRD2` = 7, `dALUCtrl` = 0, rs1 = 1, rs2 = 2, no forwarding.
  - Required: next cycle `srcA_o` = 5, `srcB_o` = 7, `ALUCtrl_o` = 0.
- Forward priority: registered rs1 = 3, EX/MEM rd = 3 with result 0xAA, MEM/WB rd = 3 with result 0xBB.
  - Required: `srcA_o` = 0xAA.
  - Drop `exmemRegWrite_i`: `srcA_o` = 0xBB.
- x0 guard: rs2 = 0, EX/MEM rd = 0, regWrite = 1, result 0xFF, registered RD2 = 0.
  - Required: `srcB_o` = 0 and `storeData_o` = 0.
- Stall/flush: 3-cycle stall → outputs frozen; then flush and stall together.
  - Required: next cycle `valid_o` = 0, `regWrite_o` = 0, `memWrite_o` = 0.
- Load-use: registered lw with rd = 4; decode presents rs1 = 4, `dValid` = 1.
  - Required: `loadUseStall_o` = 1.
  - Same with rd = 0: required `loadUseStall_o` = 0.
